// File: rtl/dungv_pkg.sv
// Shared types and encodings for the DungV core control path.
package dungv_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 6;
  localparam int IMM_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_ALU,
    S_EXEC_MEM,
    S_WB,
    S_NEXT,
    S_HALTED
  } state_e;

  localparam logic [1:0] FLAG_NOP  = 2'd0;
  localparam logic [1:0] FLAG_ALU  = 2'd1;
  localparam logic [1:0] FLAG_ALU2 = 2'd2;
  localparam logic [1:0] FLAG_MEM  = 2'd3;

  localparam logic [1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [1:0] MEMOP_STORE = 2'd2;

  function automatic logic flag_is_alu(input logic [1:0] f);
    return (f == FLAG_ALU) || (f == FLAG_ALU2);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-cycle watchdog for the sequencer's handshake states.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT-th consecutive waiting cycle.
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/dispatch control FSM for the DungV core.
// Define SEQ_PERF_CNT_EN to add the retired-instruction counter.
module core_sequencer
  import dungv_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int DEC_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               halt_req,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  input  logic [1:0]         dec_flag,
  input  logic [1:0]         dec_mem_op,
  output logic               alu_start,
  input  logic               alu_done,
  output logic               mem_start,
  input  logic               mem_done,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               fault
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        retired
`endif
);

  localparam logic [2:0] DEC_LAST = 3'(DEC_LAT - 1);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [2:0]           dec_cnt_q, dec_cnt_d;
  logic                 load_q, load_d;
  logic                 fault_q, fault_d;
  logic                 first_q;
  logic                 wd_en;
  logic                 wd_clr;
  logic                 wd_exp;

  assign wd_en =
    ((state_q == S_FETCH)    && !imem_ack) ||
    ((state_q == S_EXEC_ALU) && !alu_done) ||
    ((state_q == S_EXEC_MEM) && !mem_done);

  assign wd_clr = (state_d != state_q);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    dec_cnt_d = '0;
    load_d    = load_q;
    fault_d   = fault_q;
    imem_req  = 1'b0;
    alu_start = 1'b0;
    mem_start = 1'b0;
    rf_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run && !fault_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (wd_exp) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_DECODE: begin
        dec_cnt_d = dec_cnt_q + 3'd1;
        if (dec_cnt_q == DEC_LAST) begin
          dec_cnt_d = '0;
          load_d    = (dec_mem_op == MEMOP_LOAD);
          unique case (1'b1)
            (dec_flag == FLAG_NOP):  state_d = S_NEXT;
            flag_is_alu(dec_flag):   state_d = S_EXEC_ALU;
            (dec_flag == FLAG_MEM):  state_d = S_EXEC_MEM;
            default:                 state_d = S_NEXT;
          endcase
        end
      end
      S_EXEC_ALU: begin
        alu_start = first_q;
        if (alu_done) begin
          state_d = S_WB;
        end else if (wd_exp) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_EXEC_MEM: begin
        mem_start = first_q;
        if (mem_done) begin
          state_d = load_q ? S_WB : S_NEXT;
        end else if (wd_exp) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        pc_d    = pc_q + 1'b1;
        state_d = halt_req ? S_HALTED : S_FETCH;
      end
      S_HALTED: begin
        if (run && !fault_q) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      dec_cnt_q <= '0;
      load_q    <= 1'b0;
      fault_q   <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      dec_cnt_q <= dec_cnt_d;
      load_q    <= load_d;
      fault_q   <= fault_d;
      first_q   <= (state_d != state_q);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (state_q == S_NEXT) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr_out = instr_q;
  assign fault     = fault_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer against a
// per-instruction cycle/strobe reference model.
module tb_core_sequencer;

  localparam int PC_W    = 10;
  localparam int DEC_LAT = 2;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic            halt_req = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic [31:0]     instr_out;
  logic [1:0]      dec_flag;
  logic [1:0]      dec_mem_op;
  logic            alu_start;
  logic            alu_done = 1'b0;
  logic            mem_start;
  logic            mem_done = 1'b0;
  logic            rf_we;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            fault;

  int passed = 0;
  int total  = 0;
  int mpc    = 0;

  always #5 clk = ~clk;

  // Decoder stand-in: class in bits [1:0], memory sub-op in [3:2].
  assign dec_flag   = instr_out[1:0];
  assign dec_mem_op = instr_out[3:2];

  core_sequencer #(
    .PC_W    (PC_W),
    .DEC_LAT (DEC_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .halt_req   (halt_req),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .dec_flag   (dec_flag),
    .dec_mem_op (dec_mem_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .mem_start  (mem_start),
    .mem_done   (mem_done),
    .rf_we      (rf_we),
    .pc         (pc),
    .busy       (busy),
    .fault      (fault)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0;
    alu_done = 1'b0;
    mem_done = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle until pc moves.
  task automatic do_instr(input logic [31:0] ins, input int ack_dly,
                          input int done_dly, input bit halt);
    int  cyc, wait_a, dcnt, alus, mems, wes, exp_cyc;
    bit  in_ex, is_alu, done_ok, alu_c, mem_c, we_c;
    logic [1:0] f, mo;
    cyc = 0; wait_a = 0; dcnt = 0; alus = 0; mems = 0; wes = 0;
    in_ex = 0; is_alu = 0; done_ok = 0;
    f  = ins[1:0];
    mo = ins[3:2];
    chk("fetch_req", {63'd0, imem_req}, 64'd1);
    chk("fetch_addr", {54'd0, imem_addr}, 64'(mpc));
    for (int k = 0; k < 400; k++) begin
      idle_inputs();
      if (alu_start) begin alus++; in_ex = 1; is_alu = 1; dcnt = 0; end
      if (mem_start) begin mems++; in_ex = 1; is_alu = 0; dcnt = 0; end
      if (rf_we) wes++;
      if (halt && in_ex) halt_req = 1'b1;
      if (imem_req) begin
        if (wait_a == ack_dly) begin
          imem_ack   = 1'b1;
          imem_rdata = ins;
        end else begin
          imem_rdata = $urandom;
        end
        wait_a++;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
      end
      if (in_ex) begin
        if (is_alu) mem_done = 1'($urandom_range(0, 1));
        else        alu_done = 1'($urandom_range(0, 1));
        if (dcnt == done_dly) begin
          if (is_alu) alu_done = 1'b1;
          else        mem_done = 1'b1;
          in_ex = 0;
        end
        dcnt++;
      end else if (!imem_req) begin
        alu_done = 1'($urandom_range(0, 1));
        mem_done = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
      if (pc !== mpc[PC_W-1:0]) begin
        done_ok = 1;
        break;
      end
    end
    idle_inputs();
    alu_c   = (f == 2'd1) || (f == 2'd2);
    mem_c   = (f == 2'd3);
    we_c    = alu_c || (mem_c && mo == 2'd1);
    exp_cyc = (ack_dly + 1) + DEC_LAT + ((alu_c || mem_c) ? done_dly + 1 : 0)
              + (we_c ? 1 : 0) + 1;
    mpc = (mpc + 1) % (1 << PC_W);
    chk("instr_completes", {63'd0, done_ok}, 64'd1);
    chk("instr_cycles", 64'(cyc), 64'(exp_cyc));
    chk("alu_start_pulses", 64'(alus), 64'(alu_c));
    chk("mem_start_pulses", 64'(mems), 64'(mem_c));
    chk("rf_we_pulses", 64'(wes), 64'(we_c));
    chk("instr_out", {32'd0, instr_out}, {32'd0, ins});
    chk("pc_advance", {54'd0, pc}, 64'(mpc));
  endtask

  initial begin
    int n, wes;
    logic [31:0] r;

    // Reset state
    tick();
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_pc", {54'd0, pc}, 64'd0);
    chk("rst_instr", {32'd0, instr_out}, 64'd0);
    chk("rst_strobes", {60'd0, imem_req, alu_start, mem_start, rf_we}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", {63'd0, imem_req}, 64'd0);
    pulse_run();
    chk("run_busy", {63'd0, busy}, 64'd1);

    // Directed instructions
    do_instr(32'h0, 0, 0, 0);
    r = $urandom;
    do_instr({r[31:2], 2'b01}, 0, 3, 0);
    r = $urandom;
    do_instr({r[31:4], 4'b0111}, 1, 2, 0);
    r = $urandom;
    do_instr({r[31:4], 4'b1011}, 0, 1, 0);
    r = $urandom;
    do_instr({r[31:2], 2'b10}, 2, 0, 0);
    r = $urandom;
    do_instr({r[31:4], 4'b0011}, 0, 0, 0);
    r = $urandom;
    do_instr({r[31:4], 4'b1111}, 3, 4, 0);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      do_instr($urandom, $urandom_range(0, 5), $urandom_range(0, 5), 0);
    end

    // Halt at the instruction boundary, then resume
    r = $urandom;
    do_instr({r[31:2], 2'b01}, 1, 2, 1);
    chk("halt_busy", {63'd0, busy}, 64'd0);
    halt_req = 1'b0;
    tick();
    tick();
    chk("halt_no_req", {63'd0, imem_req}, 64'd0);
    chk("halt_pc_hold", {54'd0, pc}, 64'(mpc));
    pulse_run();
    chk("resume_req", {63'd0, imem_req}, 64'd1);
    chk("resume_addr", {54'd0, imem_addr}, 64'(mpc));

    // Walk pc up to the wrap with nops
    while (mpc != 0) begin
      r = $urandom;
      do_instr({r[31:2], 2'b00}, 0, 0, 0);
    end
    chk("wrap_addr", {54'd0, imem_addr}, 64'd0);

    // Fetch timeout
    n = 0;
    while (imem_req && n < 200) begin
      tick();
      n++;
    end
    chk("fetch_timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("fetch_fault", {63'd0, fault}, 64'd1);
    chk("fetch_fault_busy", {63'd0, busy}, 64'd0);
    pulse_run();
    tick();
    chk("fault_run_ignored", {62'd0, imem_req, busy}, 64'd0);
    chk("fault_sticky", {63'd0, fault}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("fault_cleared", {63'd0, fault}, 64'd0);
    chk("fault_rst_pc", {54'd0, pc}, 64'd0);
    mpc = 0;

    // ALU-done timeout, no writeback
    tick();
    pulse_run();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1;
    tick();
    imem_ack = 1'b0;
    n = 0;
    while (!alu_start && n < 20) begin
      tick();
      n++;
    end
    chk("alu_to_started", {63'd0, alu_start}, 64'd1);
    n = 0;
    wes = 0;
    while (!fault && n < 200) begin
      if (rf_we) wes++;
      tick();
      n++;
    end
    chk("alu_timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("alu_timeout_no_we", 64'(wes), 64'd0);
    chk("alu_timeout_pc", {54'd0, pc}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
